// File: rtl/noc_pkg.sv
// -----------------------------------------------------------------------------
// noc_pkg
// Shared NoC definitions for the router input port:
//   - flit type codes (top two bits of every flit)
//   - one-hot output port indices for a 2-D mesh
//   - per-VC state type
//   - xy_route(): dimension-ordered (X first, then Y) one-hot route
// -----------------------------------------------------------------------------
package noc_pkg;

  localparam logic [1:0] FLIT_BODY      = 2'b00;
  localparam logic [1:0] FLIT_HEAD      = 2'b01;
  localparam logic [1:0] FLIT_TAIL      = 2'b10;
  localparam logic [1:0] FLIT_HEAD_TAIL = 2'b11;

  localparam int PORT_L = 0;
  localparam int PORT_N = 1;
  localparam int PORT_E = 2;
  localparam int PORT_S = 3;
  localparam int PORT_W = 4;

  localparam int ROUTE_W     = 5;
  // Coordinates are zero-extended to this width before routing so the
  // function serves any mesh size up to 256x256.
  localparam int COORD_MAX_W = 8;

  typedef enum logic {
    VC_IDLE   = 1'b0,
    VC_ACTIVE = 1'b1
  } vc_state_t;

  // X is resolved before Y; equal coordinates in both dimensions mean Local.
  function automatic logic [ROUTE_W-1:0] xy_route(
    input logic [COORD_MAX_W-1:0] x_cur,
    input logic [COORD_MAX_W-1:0] y_cur,
    input logic [COORD_MAX_W-1:0] x_dst,
    input logic [COORD_MAX_W-1:0] y_dst
  );
    logic [ROUTE_W-1:0] r;
    r = '0;
    if (x_dst > x_cur)      r[PORT_E] = 1'b1;
    else if (x_dst < x_cur) r[PORT_W] = 1'b1;
    else if (y_dst > y_cur) r[PORT_N] = 1'b1;
    else if (y_dst < y_cur) r[PORT_S] = 1'b1;
    else                    r[PORT_L] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/vc_fifo.sv
// -----------------------------------------------------------------------------
// vc_fifo
// Single virtual-channel flit FIFO with first-word fall-through head.
// Ports:
//   clk, rst (async, active-low)
//   push / din   : write din when not full
//   pop          : drop the head flit when not empty
//   dout         : current head flit
//   full, empty  : occupancy flags, registered via count
// FIFO_DEPTH must be a power of two so the pointers wrap naturally.
// -----------------------------------------------------------------------------
module vc_fifo #(
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic                  pop,
  input  logic [DATA_WIDTH-1:0] din,
  output logic [DATA_WIDTH-1:0] dout,
  output logic                  full,
  output logic                  empty
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr;
  logic [AW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic                  push_ok;
  logic                  pop_ok;

  assign full    = (count == CW'(FIFO_DEPTH));
  assign empty   = (count == '0);
  assign push_ok = push && !full;
  assign pop_ok  = pop && !empty;
  assign dout    = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= din;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop_ok)  rd_ptr <= rd_ptr + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/input_port_vc.sv
// -----------------------------------------------------------------------------
// input_port_vc
// NoC router input port with N_VC virtual-channel FIFOs, wormhole packet
// handling and per-VC XY route latching.
// Ports:
//   clk, rst (async, active-low)
//   X_cur, Y_cur      : this router's mesh coordinates
//   val, vc_in, Data_in : upstream flit and its VC
//   ret               : per-VC not-full back to upstream
//   out_valid, vc_out, Data_out : flit presented to the switch
//   register          : one-hot route request (L,N,E,S,W = bit 0..4)
//   grant             : switch takes the presented flit
// Optional build macro INPUT_PORT_ERR_EN adds sticky output err and discards
// stray BODY/TAIL flits found at the head of an idle VC.
// -----------------------------------------------------------------------------
module input_port_vc
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int N_ADD      = 2,
  parameter int N_VC       = 2,
  parameter int FIFO_DEPTH = 4,
  parameter int N_PORT     = 5
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [N_ADD-1:0]        X_cur,
  input  logic [N_ADD-1:0]        Y_cur,
  input  logic                    val,
  input  logic [$clog2(N_VC)-1:0] vc_in,
  input  logic [DATA_WIDTH-1:0]   Data_in,
  output logic [N_VC-1:0]         ret,
  output logic                    out_valid,
  output logic [$clog2(N_VC)-1:0] vc_out,
  output logic [DATA_WIDTH-1:0]   Data_out,
  output logic [N_PORT-1:0]       register,
  input  logic                    grant
`ifdef INPUT_PORT_ERR_EN
  , output logic                  err
`endif
);

  localparam int VCW = $clog2(N_VC);

  logic [N_VC-1:0]       full, empty, push, pop;
  logic [N_VC-1:0]       head_is_head, head_is_tail;
  logic [DATA_WIDTH-1:0] head_data  [N_VC];
  logic [N_PORT-1:0]     head_route [N_VC];
  logic [N_PORT-1:0]     route_reg  [N_VC];
  vc_state_t             state      [N_VC];

  logic                  locked;
  logic [VCW-1:0]        sel_reg, rr_ptr, sel, cand, next_rr;
  logic                  found;
  logic                  pop_out;

`ifdef INPUT_PORT_ERR_EN
  logic [N_VC-1:0]       drop_pend;
`endif

  for (genvar g = 0; g < N_VC; g++) begin : g_vc
    vc_fifo #(
      .DATA_WIDTH (DATA_WIDTH),
      .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (Data_in),
      .dout  (head_data[g]),
      .full  (full[g]),
      .empty (empty[g])
    );
  end

  // Decode the head flit of every VC: type class and the route it would take.
  always_comb begin
    head_is_head = '0;
    head_is_tail = '0;
    for (int v = 0; v < N_VC; v++) begin
      head_is_head[v] = (head_data[v][DATA_WIDTH-1 -: 2] == FLIT_HEAD) ||
                        (head_data[v][DATA_WIDTH-1 -: 2] == FLIT_HEAD_TAIL);
      head_is_tail[v] = (head_data[v][DATA_WIDTH-1 -: 2] == FLIT_TAIL) ||
                        (head_data[v][DATA_WIDTH-1 -: 2] == FLIT_HEAD_TAIL);
      head_route[v] = N_PORT'(xy_route(COORD_MAX_W'(X_cur), COORD_MAX_W'(Y_cur),
                                       COORD_MAX_W'(head_data[v][N_ADD-1:0]),
                                       COORD_MAX_W'(head_data[v][2*N_ADD-1:N_ADD])));
    end
  end

  // Round-robin search from rr_ptr; a held lock overrides the search so one
  // packet owns the output until its tail leaves.
  always_comb begin
    int idx;
    found = 1'b0;
    cand  = rr_ptr;
    for (int i = 0; i < N_VC; i++) begin
      idx = (int'(rr_ptr) + i) % N_VC;
      if (!found && (state[idx] == VC_ACTIVE) && !empty[idx]) begin
        found = 1'b1;
        cand  = VCW'(idx);
      end
    end
    sel       = locked ? sel_reg : cand;
    out_valid = (state[sel] == VC_ACTIVE) && !empty[sel];
    next_rr   = (int'(sel) == N_VC - 1) ? '0 : sel + 1'b1;
  end

  assign pop_out  = out_valid && grant;
  assign ret      = ~full;
  assign vc_out   = sel;
  assign Data_out = head_data[sel];
  assign register = out_valid ? route_reg[sel] : '0;

  always_comb begin
    push = '0;
    pop  = '0;
    for (int v = 0; v < N_VC; v++) begin
      push[v] = val && (int'(vc_in) == v) && !full[v];
      pop[v]  = pop_out && (int'(sel) == v);
`ifdef INPUT_PORT_ERR_EN
      pop[v]  = pop[v] || drop_pend[v];
`endif
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int v = 0; v < N_VC; v++) begin
        state[v]     <= VC_IDLE;
        route_reg[v] <= '0;
      end
      locked  <= 1'b0;
      sel_reg <= '0;
      rr_ptr  <= '0;
`ifdef INPUT_PORT_ERR_EN
      drop_pend <= '0;
      err       <= 1'b0;
`endif
    end else begin
      for (int v = 0; v < N_VC; v++) begin
        case (state[v])
          VC_IDLE: begin
            if (!empty[v] && head_is_head[v]) begin
              route_reg[v] <= head_route[v];
              state[v]     <= VC_ACTIVE;
            end
          end
          VC_ACTIVE: begin
            if (pop[v] && head_is_tail[v]) state[v] <= VC_IDLE;
          end
        endcase
      end
`ifdef INPUT_PORT_ERR_EN
      // A stray non-head flit is flagged now and popped on the next cycle.
      for (int v = 0; v < N_VC; v++) begin
        if (drop_pend[v]) begin
          drop_pend[v] <= 1'b0;
        end else if ((state[v] == VC_IDLE) && !empty[v] && !head_is_head[v]) begin
          drop_pend[v] <= 1'b1;
          err          <= 1'b1;
        end
      end
      if (val && (int'(vc_in) < N_VC) && full[vc_in]) err <= 1'b1;
`endif
      // The comb choice made while unlocked is captured here and held.
      if (pop_out && head_is_tail[sel]) begin
        locked <= 1'b0;
        rr_ptr <= next_rr;
      end else if (out_valid) begin
        locked  <= 1'b1;
        sel_reg <= sel;
      end
    end
  end

endmodule
